// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter issuing inc/dec strobes to a
// shared 4-bit up/down counter, with a shadow copy of its value.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   req[NREQ]         per-requester request, held until ack/nack
//   dir[NREQ]         per-requester direction (1 inc, 0 dec), used at grant
//   ack[NREQ]         one-cycle pulse, operation performed
//   nack[NREQ]        one-cycle pulse, operation refused
//   cnt_inc, cnt_dec  one-cycle strobes to the shared counter
//   shadow_count      mirror of the shared counter
//   busy              high whenever a transaction is in flight
//
// Option: define COUNTER_SCHEDULER_SATURATE_EN to refuse 15+1 and 0-1;
// when undefined the counter wraps and nack is tied low.

module counter_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  dir,
    output logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  nack,
    output logic             cnt_inc,
    output logic             cnt_dec,
    output logic [WIDTH-1:0] shadow_count,
    output logic             busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   g;
    logic            gdir;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic            found;
    logic            allowed;
    logic            resp_ok;

    // Round-robin search starting at ptr; index arithmetic wraps
    // naturally because NREQ is a power of two.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + PW'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

`ifdef COUNTER_SCHEDULER_SATURATE_EN
    logic ok_q;

    always_comb begin
        if (gdir) begin
            allowed = (shadow_count != {WIDTH{1'b1}});
        end else begin
            allowed = (shadow_count != {WIDTH{1'b0}});
        end
    end

    // The verdict is taken in ISSUE, before the count moves, and
    // carried into RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ok_q <= 1'b0;
        end else if (state == ISSUE) begin
            ok_q <= allowed;
        end
    end

    assign resp_ok = ok_q;
`else
    assign allowed = 1'b1;
    assign resp_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;
        ack       = '0;
        nack      = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_inc   = allowed & gdir;
                cnt_dec   = allowed & ~gdir;
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ok) begin
                    ack[g] = 1'b1;
                end else begin
                    nack[g] = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            g            <= '0;
            gdir         <= 1'b0;
            shadow_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                g    <= pick;
                gdir <= dir[pick];
            end
            if (cnt_inc) begin
                shadow_count <= shadow_count + WIDTH'(1);
            end else if (cnt_dec) begin
                shadow_count <= shadow_count - WIDTH'(1);
            end
            if (state == RESP) begin
                ptr <= g + PW'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed and randomized checks of
// counter_scheduler against a transaction-level timeline model.

module tb_counter_scheduler;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] dir;
    logic [3:0] ack;
    logic [3:0] nack;
    logic       cnt_inc;
    logic       cnt_dec;
    logic [3:0] shadow_count;
    logic       busy;

    int tests;
    int fails;

    counter_scheduler #(.NREQ(4), .WIDTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .dir          (dir),
        .ack          (ack),
        .nack         (nack),
        .cnt_inc      (cnt_inc),
        .cnt_dec      (cnt_dec),
        .shadow_count (shadow_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 25)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Model: a short timeline of expected per-cycle outputs.
    // Slot 0 is the cycle that follows the most recent edge.
    typedef struct packed {
        logic       inc;
        logic       dec;
        logic [3:0] ack;
        logic [3:0] nack;
        logic       busy;
    } exp_t;

    exp_t sc0;
    exp_t sc1;
    int   m_count;
    int   m_ptr;
    int   m_w;
    int   m_idx;
    logic m_up;
    logic m_ok;
    logic m_was_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc0     = '0;
            sc1     = '0;
            m_count = 0;
            m_ptr   = 0;
        end else begin
            if (sc0.inc) m_count = (m_count + 1) % 16;
            if (sc0.dec) m_count = (m_count + 15) % 16;
            m_was_busy = sc0.busy;
            sc0 = sc1;
            sc1 = '0;
            if (!m_was_busy && req != 4'b0) begin
                m_w = -1;
                for (int k = 0; k < 4; k++) begin
                    m_idx = (m_ptr + k) % 4;
                    if (m_w < 0 && req[m_idx]) m_w = m_idx;
                end
                m_up = dir[m_w];
`ifdef COUNTER_SCHEDULER_SATURATE_EN
                m_ok = m_up ? (m_count != 15) : (m_count != 0);
`else
                m_ok = 1'b1;
`endif
                sc0.busy = 1'b1;
                sc0.inc  = m_ok & m_up;
                sc0.dec  = m_ok & ~m_up;
                sc1.busy = 1'b1;
                if (m_ok) sc1.ack  = 4'(1 << m_w);
                else      sc1.nack = 4'(1 << m_w);
                m_ptr = (m_w + 1) % 4;
            end
        end
    end

    // Per-cycle compare against the model plus standalone invariants.
    logic [3:0] net;

    always @(negedge clk) begin
        if (!reset_n) net = 4'd0;
        check("cycle",
              {cnt_inc, cnt_dec, ack, nack, busy, shadow_count},
              {sc0.inc, sc0.dec, sc0.ack, sc0.nack, sc0.busy,
               4'(m_count)});
        check("excl", {31'd0, cnt_inc & cnt_dec}, 32'd0);
        check("onehot", {31'd0, $countones(ack | nack) <= 1}, 32'd1);
        check("net", {28'd0, shadow_count}, {28'd0, net});
        if (cnt_inc) net = net + 4'd1;
        if (cnt_dec) net = net - 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0;
        dir     = 4'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // Waits for the response pulse; s collects any strobe seen.
    task automatic wait_resp(output logic [3:0] a, output logic [3:0] k,
                             output logic [1:0] s);
        a = 4'b0;
        k = 4'b0;
        s = 2'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            s = s | {cnt_inc, cnt_dec};
            if ((ack | nack) != 4'b0) begin
                a = ack;
                k = nack;
                return;
            end
        end
    endtask

    task automatic one_op(input logic [3:0] r, input logic [3:0] d,
                          output logic [3:0] a, output logic [3:0] k,
                          output logic [1:0] s);
        req = r;
        dir = d;
        wait_resp(a, k, s);
        req = 4'b0;
        tick();
    endtask

    logic [3:0] a;
    logic [3:0] k;
    logic [1:0] s;
    logic [3:0] seen [4];
    int         when [4];
    int         nresp;
    logic [3:0] pend;
    logic [3:0] resp;

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        req     = 4'b0;
        dir     = 4'b0;
        do_reset();

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {28'd0, shadow_count}, 32'd0);
        check("rst_resp", {24'd0, ack, nack}, 32'd0);

        // Single increment request.
        req = 4'b0001;
        dir = 4'b0001;
        tick();
        check("single_issue", {29'd0, cnt_inc, cnt_dec, busy}, 32'b101);
        tick();
        check("single_ack", {28'd0, ack}, 32'b0001);
        check("single_cnt", {28'd0, shadow_count}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd1);
        req = 4'b0;
        tick();
        check("single_done", {31'd0, busy}, 32'd0);

        // Contention: all four request, each drops after its ack.
        do_reset();
        req   = 4'b1111;
        dir   = 4'b1111;
        nresp = 0;
        for (int n = 0; n < 30 && nresp < 4; n++) begin
            tick();
            resp = ack | nack;
            if (resp != 4'b0) begin
                seen[nresp] = resp;
                when[nresp] = n;
                nresp++;
                req = req & ~resp;
            end
        end
        check("cont_count", nresp, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nresp) begin
                check("cont_order", {28'd0, seen[i]}, 32'(1 << i));
                if (i > 0)
                    check("cont_gap", when[i] - when[i-1], 3);
            end
        end
        check("cont_cnt", {28'd0, shadow_count}, 32'd4);

        // Fairness: after requester 1, requester 0 comes first.
        do_reset();
        one_op(4'b0010, 4'b0010, a, k, s);
        check("fair_first", {28'd0, a}, 32'b0010);
        req = 4'b0011;
        dir = 4'b0011;
        wait_resp(a, k, s);
        check("fair_order", {28'd0, a}, 32'b0001);
        req = 4'b0010;
        wait_resp(a, k, s);
        check("fair_second", {28'd0, a}, 32'b0010);
        req = 4'b0;
        tick();

        // Boundaries at 0 (decrement) and 15 (increment).
        do_reset();
        one_op(4'b0001, 4'b0000, a, k, s);
`ifdef COUNTER_SCHEDULER_SATURATE_EN
        check("dec0_resp", {24'd0, a, k}, 32'h01);
        check("dec0_strobe", {30'd0, s}, 32'd0);
        check("dec0_cnt", {28'd0, shadow_count}, 32'd0);
        for (int i = 0; i < 15; i++)
            one_op(4'b0001, 4'b0001, a, k, s);
        check("up15_cnt", {28'd0, shadow_count}, 32'd15);
        one_op(4'b0001, 4'b0001, a, k, s);
        check("inc15_resp", {24'd0, a, k}, 32'h01);
        check("inc15_strobe", {30'd0, s}, 32'd0);
        check("inc15_cnt", {28'd0, shadow_count}, 32'd15);
`else
        check("dec0_resp", {24'd0, a, k}, 32'h10);
        check("dec0_strobe", {30'd0, s}, 32'b01);
        check("dec0_cnt", {28'd0, shadow_count}, 32'd15);
        one_op(4'b0001, 4'b0001, a, k, s);
        check("inc15_resp", {24'd0, a, k}, 32'h10);
        check("inc15_strobe", {30'd0, s}, 32'b10);
        check("inc15_cnt", {28'd0, shadow_count}, 32'd0);
`endif

        // Reset during ISSUE aborts the transaction.
        do_reset();
        req = 4'b0001;
        dir = 4'b0001;
        tick();
        check("abort_pre", {31'd0, cnt_inc}, 32'd1);
        reset_n = 1'b0;
        req     = 4'b0;
        #1;
        check("abort_strobe", {30'd0, cnt_inc, cnt_dec}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cnt", {28'd0, shadow_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_resp", {24'd0, ack, nack}, 32'd0);
        end
        reset_n = 1'b1;
        tick();
        check("abort_idle", {27'd0, busy, shadow_count}, 32'd0);

        // Random run with well-behaved requesters.
        do_reset();
        pend = 4'b0;
        for (int n = 0; n < 1000; n++) begin
            tick();
            resp = ack | nack;
            pend = pend & ~resp;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && !resp[i] && ($urandom % 4) == 0) begin
                    pend[i] = 1'b1;
                    dir[i]  = 1'($urandom);
                end else if (pend[i] && ($urandom % 8) == 0) begin
                    dir[i] = ~dir[i];
                end
            end
            req = pend;
        end
        req = 4'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
